// File: rtl/hcsr04_emulator_if.sv
// Trigger/echo link between an HC-SR04 initiator (master) and the sensor emulator (slave).
interface hcsr04_emulator_if;
    localparam int unsigned BCD_W   = 12;
    localparam int unsigned STATE_W = 3;

    logic               trigger;
    logic [BCD_W-1:0]   distance_bcd;
    logic               echo;
    logic               busy;
    logic               trig_err;
    logic [STATE_W-1:0] db_estado;

    modport master (
        output trigger,
        output distance_bcd,
        input  echo,
        input  busy,
        input  trig_err,
        input  db_estado
    );

    modport slave (
        input  trigger,
        input  distance_bcd,
        output echo,
        output busy,
        output trig_err,
        output db_estado
    );
endinterface

// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder: validates trigger width, waits the burst time, echoes a BCD distance.
// Optional HCSR04_EMU_JITTER_EN adds an 8-bit LFSR value to every echo width.
module hcsr04_emulator #(
    parameter int unsigned TRIG_MIN_CYCLES = 500,
    parameter int unsigned BURST_CYCLES    = 10_000,
    parameter int unsigned CYCLES_PER_CM   = 2941,
    parameter int unsigned MAX_CM          = 400,
    parameter int unsigned TIMEOUT_CYCLES  = 1_900_000,
    parameter int unsigned HOLDOFF_CYCLES  = 500_000
) (
    input  logic              clock,
    input  logic              reset,
    hcsr04_emulator_if.slave  bus
);
    localparam int unsigned W_W     = 24;
    localparam int unsigned CM_W    = 10;
    localparam int unsigned DIGIT_W = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TRIG    = 3'd1,
        BURST   = 3'd2,
        ECHO    = 3'd3,
        HOLDOFF = 3'd4
    } state_t;

    state_t             state, state_next;
    logic [W_W-1:0]     count, count_next;
    logic [W_W-1:0]     width, width_next;
    logic               trig_meta, trig_s;
    logic               echo_next, busy_next, trig_err_next;
    logic               lfsr_step_c;

    logic [DIGIT_W-1:0] hun_c, ten_c, unit_c;
    logic [CM_W-1:0]    cm_raw_c, cm_c;
    logic [W_W-1:0]     base_c;
    logic [W_W-1:0]     width_calc_c;

    // Two-flop synchronizer for the asynchronous trigger
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            trig_meta <= 1'b0;
            trig_s    <= 1'b0;
        end else begin
            trig_meta <= bus.trigger;
            trig_s    <= trig_meta;
        end
    end

    // Distance to echo width: clamp bad digits, treat 0 cm as 1 cm, out of range -> timeout
    always_comb begin
        hun_c    = (bus.distance_bcd[11:8] > 4'd9) ? 4'd9 : bus.distance_bcd[11:8];
        ten_c    = (bus.distance_bcd[7:4]  > 4'd9) ? 4'd9 : bus.distance_bcd[7:4];
        unit_c   = (bus.distance_bcd[3:0]  > 4'd9) ? 4'd9 : bus.distance_bcd[3:0];
        cm_raw_c = CM_W'(hun_c) * CM_W'(100) + CM_W'(ten_c) * CM_W'(10) + CM_W'(unit_c);
        cm_c     = (cm_raw_c == '0) ? CM_W'(1) : cm_raw_c;
        base_c   = (32'(cm_c) <= MAX_CM) ? W_W'(cm_c) * W_W'(CYCLES_PER_CM)
                                         : W_W'(TIMEOUT_CYCLES);
    end

`ifdef HCSR04_EMU_JITTER_EN
    logic [7:0] lfsr;

    // x^8+x^6+x^5+x^4+1, stepped once per accepted trigger after its value is used
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else if (lfsr_step_c) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign width_calc_c = base_c + W_W'(lfsr);
`else
    logic unused_lfsr_step;

    assign unused_lfsr_step = lfsr_step_c;
    assign width_calc_c     = base_c;
`endif

    // State, shared counter, latched width and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            width        <= '0;
            bus.echo     <= 1'b0;
            bus.busy     <= 1'b0;
            bus.trig_err <= 1'b0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            width        <= width_next;
            bus.echo     <= echo_next;
            bus.busy     <= busy_next;
            bus.trig_err <= trig_err_next;
        end
    end

    assign bus.db_estado = state;

    // Next-state logic; one counter serves trigger width, burst, echo and holdoff timing
    always_comb begin
        state_next    = state;
        count_next    = count;
        width_next    = width;
        trig_err_next = 1'b0;
        lfsr_step_c   = 1'b0;

        case (state)
            IDLE: begin
                if (trig_s) begin
                    state_next = TRIG;
                    count_next = W_W'(1);
                end
            end

            TRIG: begin
                if (trig_s) begin
                    if (count < W_W'(TRIG_MIN_CYCLES)) begin
                        count_next = count + W_W'(1);
                    end
                end else if (count >= W_W'(TRIG_MIN_CYCLES)) begin
                    state_next  = BURST;
                    count_next  = '0;
                    width_next  = width_calc_c;
                    lfsr_step_c = 1'b1;
                end else begin
                    state_next    = IDLE;
                    count_next    = '0;
                    trig_err_next = 1'b1;
                end
            end

            BURST: begin
                if (count == W_W'(BURST_CYCLES - 1)) begin
                    state_next = ECHO;
                    count_next = '0;
                end else begin
                    count_next = count + W_W'(1);
                end
            end

            ECHO: begin
                if (count == width - W_W'(1)) begin
                    state_next = HOLDOFF;
                    count_next = '0;
                end else begin
                    count_next = count + W_W'(1);
                end
            end

            HOLDOFF: begin
                // A trigger still high at the end must be released before re-arming
                if (count < W_W'(HOLDOFF_CYCLES - 1)) begin
                    count_next = count + W_W'(1);
                end else if (!trig_s) begin
                    state_next = IDLE;
                    count_next = '0;
                end
            end

            default: begin
                state_next = IDLE;
                count_next = '0;
            end
        endcase

        echo_next = (state_next == ECHO);
        busy_next = (state_next == BURST) || (state_next == ECHO) || (state_next == HOLDOFF);
    end
endmodule

// File: tb/tb_hcsr04_emulator.sv
// Scoreboard bench for hcsr04_emulator with shortened timing parameters and random transactions.
module tb_hcsr04_emulator;
    localparam int unsigned TMIN  = 20;
    localparam int unsigned BURST = 30;
    localparam int unsigned CPC   = 5;
    localparam int unsigned MAXCM = 400;
    localparam int unsigned TOUT  = 2100;
    localparam int unsigned HOLD  = 150;

    typedef struct {
        int unsigned burst;
        int unsigned rise;
        int unsigned width;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    exp_t        acc_q[$];
    int unsigned err_q[$];
    int unsigned idle_q[$];
    logic [7:0]  lfsr_m;

    hcsr04_emulator_if bus ();

    hcsr04_emulator #(
        .TRIG_MIN_CYCLES (TMIN),
        .BURST_CYCLES    (BURST),
        .CYCLES_PER_CM   (CPC),
        .MAX_CM          (MAXCM),
        .TIMEOUT_CYCLES  (TOUT),
        .HOLDOFF_CYCLES  (HOLD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: echo width straight from the distance rules
    function automatic int unsigned model_width(input logic [11:0] bcd);
        int unsigned h, t, u, cm;
        h = 32'(bcd[11:8]);
        t = 32'(bcd[7:4]);
        u = 32'(bcd[3:0]);
        if (h > 9) h = 9;
        if (t > 9) t = 9;
        if (u > 9) u = 9;
        cm = h * 100 + t * 10 + u;
        if (cm == 0) cm = 1;
        if (cm > MAXCM) return TOUT;
        return cm * CPC;
    endfunction

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(posedge clock);
        #1;
    endtask

    task automatic pulse(input int unsigned n);
        bus.trigger = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        bus.trigger = 1'b0;
    endtask

    // Issue one trigger of tw cycles; k = cycle of the trigger fall
    task automatic send(input logic [11:0] bcd, input int unsigned tw,
                        output int unsigned k, output int unsigned w);
        exp_t e;
        bus.distance_bcd = bcd;
        @(posedge clock);
        #1;
        bus.trigger = 1'b1;
        repeat (tw) @(posedge clock);
        #1;
        bus.trigger = 1'b0;
        k = cyc;
        if (tw >= TMIN) begin
            w = model_width(bcd);
`ifdef HCSR04_EMU_JITTER_EN
            w = w + 32'(lfsr_m);
            lfsr_m = lfsr_next(lfsr_m);
`endif
            e.burst = k + 3;
            e.rise  = k + BURST + 3;
            e.width = w;
            acc_q.push_back(e);
        end else begin
            w = 0;
            err_q.push_back(k + 3);
        end
        repeat (3) @(posedge clock);
        #1;
        bus.distance_bcd = 12'($urandom);
    endtask

    task automatic send_normal(input logic [11:0] bcd, input int unsigned tw);
        int unsigned k, w, free;
        send(bcd, tw, k, w);
        if (tw >= TMIN) begin
            idle_q.push_back(k + BURST + 3 + w + HOLD);
            free = k + BURST + 3 + w + HOLD + 2;
        end else begin
            free = k + 5;
        end
        wait_until(free);
    endtask

    // Monitor: compares every DUT output event against the expectation queues
    exp_t        mon_e;
    logic        prev_echo = 1'b0, prev_busy = 1'b0, busy_gap = 1'b0;
    int unsigned echo_rise = 0, want_width = 0;

    always @(negedge clock) begin
        if (reset) begin
            prev_echo = 1'b0;
            prev_busy = 1'b0;
            busy_gap  = 1'b0;
            idle_q.delete();
        end else begin
            if (bus.trig_err) begin
                check("trig_err_expected", longint'(err_q.size() > 0), 1);
                if (err_q.size() > 0) check("trig_err_cycle", cyc, err_q.pop_front());
            end
            if (bus.busy && !prev_busy) begin
                check("busy_rise_expected", longint'(acc_q.size() > 0), 1);
                if (acc_q.size() > 0) check("busy_rise_cycle", cyc, acc_q[0].burst);
            end
            if (!bus.busy && prev_busy) begin
                check("busy_fall_expected", longint'(idle_q.size() > 0), 1);
                if (idle_q.size() > 0) check("busy_fall_cycle", cyc, idle_q.pop_front());
            end
            if (bus.echo && !prev_echo) begin
                check("echo_expected", longint'(acc_q.size() > 0), 1);
                if (acc_q.size() > 0) begin
                    mon_e = acc_q.pop_front();
                    check("echo_rise_cycle", cyc, mon_e.rise);
                    want_width = mon_e.width;
                end
                echo_rise = cyc;
                busy_gap  = 1'b0;
            end
            if (bus.echo && !bus.busy) busy_gap = 1'b1;
            if (!bus.echo && prev_echo) begin
                check("echo_width", cyc - echo_rise, want_width);
                check("busy_during_echo", busy_gap, 0);
            end
            prev_echo = bus.echo;
            prev_busy = bus.busy;
        end
    end

    initial begin
        int unsigned k, w, r;
        logic [11:0] rb;
        int unsigned rt;

        reset            = 1'b1;
        bus.trigger      = 1'b0;
        bus.distance_bcd = 12'h000;
        lfsr_m           = 8'hA5;
        #12;
        check("reset_echo", bus.echo, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_trig_err", bus.trig_err, 0);
        check("reset_state", bus.db_estado, 0);
        wait_until(4);
        reset = 1'b0;
        wait_until(8);

        // Basic measurement, short trigger, trigger width boundaries
        send_normal(12'h010, TMIN + 10);
        send_normal(12'h010, TMIN - 10);
        check("idle_after_err", bus.db_estado, 0);
        send_normal(12'h123, TMIN - 1);
        send_normal(12'h020, TMIN);

        // Range boundaries, zero distance, invalid digits
        send_normal(12'h450, TMIN + 2);
        send_normal(12'h000, TMIN + 2);
        send_normal(12'h0A5, TMIN + 2);
        send_normal(12'h400, TMIN + 2);
        send_normal(12'h401, TMIN + 2);
        send_normal(12'hFFF, TMIN + 2);

        // Triggers during ECHO and HOLDOFF are ignored; a held trigger blocks re-arming
        send(12'h100, TMIN + 5, k, w);
        r = k + BURST + 3;
        wait_until(r + 100);
        pulse(TMIN + 5);
        wait_until(r + w + 30);
        pulse(TMIN + 5);
        wait_until(r + w + HOLD - 40);
        bus.trigger = 1'b1;
        wait_until(r + w + HOLD + 30);
        check("held_state", bus.db_estado, 4);
        check("held_busy", bus.busy, 1);
        bus.trigger = 1'b0;
        idle_q.push_back(cyc + 3);
        wait_until(cyc + 10);
        check("held_release_state", bus.db_estado, 0);

        // Reset in the middle of an echo
        send(12'h200, TMIN, k, w);
        wait_until(k + BURST + 3 + 300);
        #1;
        reset = 1'b1;
        #1;
        check("midreset_echo", bus.echo, 0);
        check("midreset_busy", bus.busy, 0);
        check("midreset_state", bus.db_estado, 0);
        lfsr_m = 8'hA5;
        wait_until(cyc + 3);
        reset = 1'b0;
        wait_until(cyc + 5);
        check("post_reset_busy", bus.busy, 0);
        check("post_reset_state", bus.db_estado, 0);
        send_normal(12'h010, TMIN + 3);

        // Random transactions
        for (int i = 0; i < 14; i++) begin
            rb = {4'($urandom_range(6, 0)), 4'($urandom_range(11, 0)), 4'($urandom_range(11, 0))};
            rt = $urandom_range(TMIN + 12, TMIN - 4);
            send_normal(rb, rt);
        end

        wait_until(cyc + 20);
        check("echo_queue_drained", acc_q.size(), 0);
        check("err_queue_drained", err_q.size(), 0);
        check("idle_queue_drained", idle_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
